// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a first-word-fall-through FIFO read port and
// sends each one as a UART frame: start bit, LSB-first data, optional even
// parity, then 1 or 2 stop bits. Runs entirely on the FIFO read clock.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_WIDTH);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] BIT_ONE   = IW'(1);
    localparam logic [IW-1:0] BIT_ZERO  = IW'(0);
    localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t                state_q,     state_d;
    logic [BW-1:0]         baud_q,      baud_d;
    logic [IW-1:0]         bit_q,       bit_d;
    logic                  stop_q,      stop_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic                  par_q,       par_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  tx_q,        tx_d;
    logic                  fifo_r_en_q, fifo_r_en_d;
    logic                  busy_q,      busy_d;

    logic baud_end_s;
    logic can_start_s;

    // Even-parity bit of a captured word.
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] w);
        return ^w;
    endfunction

    assign baud_end_s  = (baud_q == BAUD_LAST);
    assign can_start_s = tx_en & ~fifo_empty;

    // Next-state logic; outputs are derived from the next state so that
    // tx, fifo_r_en and busy all come straight from flops.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        par_d       = par_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                baud_d = BAUD_ZERO;
                if (can_start_s) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // The FIFO pops on this same edge, so capture the head word now.
                shift_d = fifo_data;
                par_d   = even_parity(fifo_data);
                baud_d  = BAUD_ZERO;
                bit_d   = BIT_ZERO;
                stop_d  = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_end_s) begin
                    baud_d  = BAUD_ZERO;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_d  = BAUD_ZERO;
                    shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = BIT_ZERO;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_PARITY: begin
                if (baud_end_s) begin
                    baud_d  = BAUD_ZERO;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_d = BAUD_ZERO;
                    if (stop_q == STOP_LAST) begin
                        // Last stop cycle: the only point, besides IDLE, where
                        // the FIFO flag and tx_en are looked at.
                        stop_d      = 1'b0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        if (can_start_s) begin
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase

        fifo_r_en_d = (state_d == S_LOAD);
        busy_d      = (state_d != S_IDLE);
    end

    // State, datapath and registered outputs; reset abandons any frame.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q     <= S_IDLE;
            baud_q      <= BAUD_ZERO;
            bit_q       <= BIT_ZERO;
            stop_q      <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
            tx_q        <= 1'b1;
            fifo_r_en_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            frame_cnt_q <= frame_cnt_d;
            tx_q        <= tx_d;
            fifo_r_en_q <= fifo_r_en_d;
            busy_q      <= busy_d;
        end
    end

    assign fifo_r_en = fifo_r_en_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule
